// File: rtl/dmem_wbuf.sv
// dmem_wbuf: M-stage data memory with a posted-write FIFO, slow retire and store-to-load forwarding
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   MemWriteM  store request          MemReadM   load request
//   ALUOutM    byte address           WriteDataM store data
//   ReadDataM  combinational load data (youngest pending store, else array)
//   StallM     store refused this cycle; requester holds its inputs
//   BufCount   pending FIFO entries
module dmem_wbuf #(
  parameter int ADDR_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int WR_LATENCY = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               MemWriteM,
  input  logic                               MemReadM,
  input  logic [31:0]                        ALUOutM,
  input  logic [31:0]                        WriteDataM,
  output logic [31:0]                        ReadDataM,
  output logic                               StallM,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     BufCount
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int LW = WR_LATENCY > 1 ? $clog2(WR_LATENCY) : 1;
  localparam logic [LW-1:0] RELOAD = LW'(WR_LATENCY - 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] idx_q [BUF_DEPTH];
  logic [31:0] dat_q [BUF_DEPTH];
  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic push, pop, hit;
  logic [31:0] fwd;
  logic unused_addr;
  assign idx = ALUOutM[ADDR_WIDTH+1:2];
  // byte offset and high address bits alias onto the same word
  assign unused_addr = ^{ALUOutM[31:ADDR_WIDTH+2], ALUOutM[1:0]};
  assign pop = state_q == BUSY && cnt_q == '0;
  // a retiring head frees a slot in the same cycle, so a full FIFO still accepts
  assign StallM = MemWriteM && count_q == FULL && !pop;
  assign push = MemWriteM && !StallM;
  assign BufCount = count_q;
  always_comb begin
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    state_d = state_q == IDLE ? (count_q != '0 ? BUSY : IDLE) : (pop && count_d == '0 ? IDLE : BUSY);
    cnt_d = (state_q == IDLE || pop) ? RELOAD : cnt_q - 1'b1;
  end
  // scan oldest to youngest so the last match (youngest store) wins
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (CW'(k) < count_q && idx_q[head_q + PW'(k)] == idx) begin
        hit = 1'b1;
        fwd = dat_q[head_q + PW'(k)];
      end
    end
  end
  assign ReadDataM = hit ? fwd : mem_q[idx];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // payload and backing array carry no reset; the array survives reset and
  // pop is held low while reset is asserted because the FSM sits in IDLE
  always_ff @(posedge clk) begin
    if (push) begin
      idx_q[tail_q] <= idx;
      dat_q[tail_q] <= WriteDataM;
    end
    if (pop) mem_q[idx_q[head_q]] <= dat_q[head_q];
  end
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: directed and random checks of dmem_wbuf against a timestamped queue model
module tb_dmem_wbuf;
  localparam int L = 3;
  localparam int D = 4;
  logic clk = 0, reset = 0, MemWriteM = 0, MemReadM = 0;
  logic [31:0] ALUOutM = 0, WriteDataM = 0;
  logic [31:0] ReadDataM;
  logic StallM;
  logic [2:0] BufCount;
  dmem_wbuf dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .BufCount(BufCount)
  );
  always #5 clk = ~clk;
  // each pending store carries the clock edge at which it retires
  typedef struct {logic [7:0] ix; logic [31:0] d; int ret;} ent_t;
  ent_t q[$];
  logic [31:0] mem_m [256];
  bit known_m [256];
  int cyc = 0, vectors = 0, miscompares = 0, s = 0;
  logic last_acc = 0, stall_seen = 0;
  logic [31:0] rd_seen = 0;
  logic [2:0] cnt_seen = 0;
  always @(posedge clk) assert (!(MemReadM && MemWriteM)) else $error("read and write requested together");
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    logic stall_m;
    logic [7:0] ix;
    logic [31:0] rexp;
    bit hit;
    int t;
    MemWriteM = wr;
    MemReadM = rd;
    ALUOutM = a;
    WriteDataM = d;
    ix = a[9:2];
    t = cyc + 1;
    stall_m = 0;
    if (wr && q.size() == D) stall_m = q[0].ret != t;
    @(negedge clk);
    stall_seen = StallM;
    cnt_seen = BufCount;
    rd_seen = ReadDataM;
    chk("stall", StallM, stall_m);
    chk("count", BufCount, q.size());
    if (rd) begin
      hit = 0;
      rexp = '0;
      for (int i = q.size() - 1; i >= 0 && !hit; i--)
        if (q[i].ix == ix) begin
          hit = 1;
          rexp = q[i].d;
        end
      if (!hit && known_m[ix]) begin
        hit = 1;
        rexp = mem_m[ix];
      end
      if (hit) chk("rdata", ReadDataM, rexp);
    end
    @(posedge clk);
    cyc++;
    last_acc = wr && !stall_m;
    if (last_acc) begin
      e.ix = ix;
      e.d = d;
      // empty FIFO costs one extra cycle for the drain to notice it
      e.ret = q.size() > 0 ? q[$].ret + L : t + L + 1;
    end
    if (q.size() > 0 && q[0].ret == t) begin
      mem_m[q[0].ix] = q[0].d;
      known_m[q[0].ix] = 1;
      void'(q.pop_front());
    end
    if (last_acc) q.push_back(e);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    bit done = 0;
    stalls = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(1, 0, a, d);
      if (last_acc) done = 1;
      else stalls++;
    end
    if (!done) chk("store_timeout", 0, 1);
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] exp);
    cycle(0, 1, a, 0);
    chk("load", rd_seen, exp);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) cycle(0, 0, 0, 0);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    cycle(0, 0, 0, 0);
    chk("drained_count", cnt_seen, 0);
  endtask
  initial begin
    logic w, r;
    logic [31:0] a, d;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", StallM, 0);
    chk("rst_count", BufCount, 0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    store(32'h10, 32'h12345678, s);
    chk("t1_stalls", s, 0);
    load(32'h10, 32'h12345678);
    chk("t1_count1", cnt_seen, 1);
    idle(5);
    load(32'h10, 32'h12345678);
    chk("t1_count0", cnt_seen, 0);
    store(32'h20, 32'h0000000A, s);
    store(32'h20, 32'h0000000B, s);
    load(32'h20, 32'h0000000B);
    drain();
    load(32'h20, 32'h0000000B);
    for (int k = 0; k < 6; k++) begin
      store(32'h100 + 4 * k, 32'hA000 + k, s);
      chk("t3_stalls", s, k == 5 ? 2 : 0);
    end
    drain();
    for (int k = 0; k < 6; k++) load(32'h100 + 4 * k, 32'hA000 + k);
    store(32'h40, 32'h00000001, s);
    drain();
    store(32'h44, 32'h44, s);
    store(32'h48, 32'h48, s);
    store(32'h4C, 32'h4C, s);
    store(32'h50, 32'h50, s);
    store(32'h40, 32'hDEADBEEF, s);
    MemWriteM = 1;
    ALUOutM = 32'h54;
    #1;
    chk("t4_full_stall", StallM, 1);
    reset = 0;
    #1;
    chk("t4_rst_stall", StallM, 0);
    chk("t4_rst_count", BufCount, 0);
    q.delete();
    MemWriteM = 0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1;
    @(posedge clk);
    #1;
    load(32'h40, 32'h00000001);
    chk("t4_count", cnt_seen, 0);
    store(32'h13, 32'hCAFEF00D, s);
    load(32'h10, 32'hCAFEF00D);
    store(32'h400, 32'h55, s);
    drain();
    load(32'h0, 32'h55);
    store(32'h84, 32'h77, s);
    drain();
    store(32'h80, 32'h99, s);
    repeat (4) load(32'h84, 32'h77);
    drain();
    load(32'h80, 32'h99);
    w = 0;
    r = 0;
    a = 0;
    d = 0;
    for (int i = 0; i < 600; i++) begin
      if (!(w && !last_acc)) begin
        int op = $urandom_range(0, 9);
        w = op < 4;
        r = op >= 4 && op < 8;
        a = $urandom;
        a[9:2] = 8'($urandom_range(0, 15));
        d = $urandom;
      end
      cycle(w, r, a, d);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
